// File: rtl/div_pkg.sv
// Shared constants for the sequential signed divider: FSM encodings and counter sizing.
// Latency: none (package only).
// Backpressure: none (package only).
package div_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int N_DEFAULT = 5;
    localparam int CNT_W     = $clog2(N_DEFAULT + 1);

    // Iteration counter must hold the value N itself, hence N+1 codes.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/abs_n.sv
// Two's-complement magnitude of an N-bit signed value, returned as N-bit unsigned.
// Latency: combinational.
// Backpressure: none.
module abs_n #(
    parameter int N = 5
) (
    input  logic [N-1:0] x,
    output logic [N-1:0] mag
);

    // The most negative input negates to 2^(N-1), which still fits N unsigned bits.
    assign mag = x[N-1] ? N'(~x + 1'b1) : x;

endmodule

// File: rtl/seq_div.sv
// Signed restoring divider, one quotient bit per clock; magnitude outputs plus sign flags.
// Latency: N+1 clocks from start being presented to ready (one clock when B == 0).
// Backpressure: start is ignored while busy; results hold in DONE until the next start.
module seq_div
    import div_pkg::*;
#(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] QUOTIENT,
    output logic [N-1:0] REMAINDER,
    output logic         q_neg,
    output logic         r_neg,
    output logic         div_by_zero,
    output logic         ready,
    output logic         busy
);

    localparam int CW = cnt_width(N);

    logic [1:0]    state;
    logic [1:0]    state_nxt;

    logic [N-1:0]  q_reg;      // dividend shifting out, quotient shifting in
    logic [N:0]    rem_reg;    // partial remainder, one guard bit for the subtract sign
    logic [N-1:0]  div_reg;
    logic [CW-1:0] cnt;
    logic          q_sign;
    logic          r_sign;
    logic          dz_reg;

    logic [N-1:0]  a_mag;
    logic [N-1:0]  b_mag;
    logic [N:0]    rem_shift;
    logic [N:0]    rem_diff;
    logic          sub_ok;
    logic          accept;
    logic          b_zero;

    abs_n #(.N(N)) u_abs_a (.x(A), .mag(a_mag));
    abs_n #(.N(N)) u_abs_b (.x(B), .mag(b_mag));

    assign accept    = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign b_zero    = (B == '0);

    // Remainder can never reach 2*D, so the N+1 bit difference sign is exact.
    assign rem_shift = {rem_reg[N-1:0], q_reg[N-1]};
    assign rem_diff  = rem_shift - {1'b0, div_reg};
    assign sub_ok    = ~rem_diff[N];

    // State register; reset abandons any in-flight division.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept a request from IDLE/DONE, leave CALC after the last bit.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = b_zero ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (cnt == CW'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: operand capture on accept, one shift/subtract step per CALC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg   <= '0;
            rem_reg <= '0;
            div_reg <= '0;
            cnt     <= '0;
            q_sign  <= 1'b0;
            r_sign  <= 1'b0;
            dz_reg  <= 1'b0;
        end else if (accept) begin
            q_sign <= A[N-1] ^ B[N-1];
            r_sign <= A[N-1];
            if (b_zero) begin
                q_reg   <= '1;
                rem_reg <= {1'b0, a_mag};
                div_reg <= '0;
                cnt     <= '0;
                dz_reg  <= 1'b1;
            end else begin
                q_reg   <= a_mag;
                rem_reg <= '0;
                div_reg <= b_mag;
                cnt     <= CW'(N);
                dz_reg  <= 1'b0;
            end
        end else if (state == ST_CALC) begin
            rem_reg <= sub_ok ? rem_diff : rem_shift;
            q_reg   <= {q_reg[N-2:0], sub_ok};
            cnt     <= cnt - CW'(1);
        end
    end

    // Outputs: status from state, sign flags suppressed on zero magnitudes.
    always_comb begin
        busy        = (state == ST_CALC);
        ready       = (state == ST_DONE);
        QUOTIENT    = q_reg;
        REMAINDER   = rem_reg[N-1:0];
        q_neg       = q_sign & (|q_reg);
        r_neg       = r_sign & (|rem_reg[N-1:0]);
        div_by_zero = dz_reg;
    end

endmodule

// File: tb/tb_seq_div.sv
module tb_seq_div;

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] A;
    logic [4:0] B;
    logic [4:0] QUOTIENT;
    logic [4:0] REMAINDER;
    logic       q_neg;
    logic       r_neg;
    logic       div_by_zero;
    logic       ready;
    logic       busy;

    int total;
    int bad;

    seq_div #(.N(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .A           (A),
        .B           (B),
        .QUOTIENT    (QUOTIENT),
        .REMAINDER   (REMAINDER),
        .q_neg       (q_neg),
        .r_neg       (r_neg),
        .div_by_zero (div_by_zero),
        .ready       (ready),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents start for one clock, then waits (bounded) for ready.
    // lat counts rising edges from the edge start was raised after.
    task automatic run_op(input int a, input int b, output int lat, output int busy_n,
                          output logic first_rdy);
        int av;
        int bv;
        av = a;
        bv = b;
        @(posedge clk); #1;
        A = av[4:0];
        B = bv[4:0];
        start = 1'b1;
        lat = 0;
        busy_n = 0;
        first_rdy = 1'b0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (lat == 1) first_rdy = ready;
            if (busy) busy_n++;
        end while (!ready && lat < 40);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        A = 5'd13;
        B = 5'd4;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({QUOTIENT, REMAINDER, q_neg, r_neg, div_by_zero, ready, busy} !== 15'd0) begin
            bad++;
            $display("FAIL reset_outputs: got Q=%0d R=%0d qn=%b rn=%b dz=%b rdy=%b busy=%b required all 0",
                     QUOTIENT, REMAINDER, q_neg, r_neg, div_by_zero, ready, busy);
        end
        rst = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        int bn;
        logic fr;
        run_op(13, 4, lat, bn, fr);
        total++;
        if (lat !== 6) begin
            bad++;
            $display("FAIL basic_latency: got %0d required 6", lat);
        end
        total++;
        if (bn !== 5) begin
            bad++;
            $display("FAIL basic_busy_cycles: got %0d required 5", bn);
        end
        total++;
        if ({QUOTIENT, REMAINDER, q_neg, r_neg, div_by_zero} !== {5'd3, 5'd1, 3'b000}) begin
            bad++;
            $display("FAIL basic_result: got Q=%0d R=%0d qn=%b rn=%b dz=%b required Q=3 R=1 qn=0 rn=0 dz=0",
                     QUOTIENT, REMAINDER, q_neg, r_neg, div_by_zero);
        end
    endtask

    task automatic test_signs();
        // a, b, |q|, |r|, q_neg, r_neg
        int vec [7][6] = '{
            '{-13,  4,  3, 1, 1, 1},
            '{ 13, -4,  3, 1, 1, 0},
            '{-13, -4,  3, 1, 0, 1},
            '{-16,  1, 16, 0, 1, 0},
            '{  3,  7,  0, 3, 0, 0},
            '{ -3,  7,  0, 3, 0, 1},
            '{-12,  4,  3, 0, 1, 0}
        };
        int lat;
        int bn;
        logic fr;
        for (int i = 0; i < 7; i++) begin
            run_op(vec[i][0], vec[i][1], lat, bn, fr);
            total++;
            if (lat !== 6 || int'(QUOTIENT) !== vec[i][2] || int'(REMAINDER) !== vec[i][3] ||
                int'(q_neg) !== vec[i][4] || int'(r_neg) !== vec[i][5] || div_by_zero !== 1'b0) begin
                bad++;
                $display("FAIL signs_%0d (%0d/%0d): got lat=%0d Q=%0d R=%0d qn=%b rn=%b dz=%b required lat=6 Q=%0d R=%0d qn=%0d rn=%0d dz=0",
                         i, vec[i][0], vec[i][1], lat, QUOTIENT, REMAINDER, q_neg, r_neg, div_by_zero,
                         vec[i][2], vec[i][3], vec[i][4], vec[i][5]);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat;
        int bn;
        logic fr;
        run_op(7, 0, lat, bn, fr);
        total++;
        if (lat !== 1 || bn !== 0) begin
            bad++;
            $display("FAIL div0_latency: got lat=%0d busy=%0d required lat=1 busy=0", lat, bn);
        end
        total++;
        if ({QUOTIENT, REMAINDER, div_by_zero, q_neg, r_neg} !== {5'b11111, 5'd7, 3'b100}) begin
            bad++;
            $display("FAIL div0_result: got Q=%0d R=%0d dz=%b qn=%b rn=%b required Q=31 R=7 dz=1 qn=0 rn=0",
                     QUOTIENT, REMAINDER, div_by_zero, q_neg, r_neg);
        end
        run_op(8, 2, lat, bn, fr);
        total++;
        if (fr !== 1'b0 || lat !== 6) begin
            bad++;
            $display("FAIL div0_followup_timing: got first_ready=%b lat=%0d required 0 and 6", fr, lat);
        end
        total++;
        if ({QUOTIENT, REMAINDER, div_by_zero} !== {5'd4, 5'd0, 1'b0}) begin
            bad++;
            $display("FAIL div0_followup_result: got Q=%0d R=%0d dz=%b required Q=4 R=0 dz=0",
                     QUOTIENT, REMAINDER, div_by_zero);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int bn;
        logic fr;
        run_op(-13, -4, lat, bn, fr);
        total++;
        if (fr !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ready_drop: got ready=%b after restart required 0", fr);
        end
        total++;
        if (lat !== 6 || {QUOTIENT, REMAINDER, q_neg, r_neg} !== {5'd3, 5'd1, 2'b01}) begin
            bad++;
            $display("FAIL b2b_result: got lat=%0d Q=%0d R=%0d qn=%b rn=%b required lat=6 Q=3 R=1 qn=0 rn=1",
                     lat, QUOTIENT, REMAINDER, q_neg, r_neg);
        end
    endtask

    task automatic test_restart_ignored();
        int lat;
        @(posedge clk); #1;
        A = 5'd13;
        B = 5'd4;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        A = 5'd7;
        B = 5'd1;
        @(posedge clk); #1;
        start = 1'b0;
        A = 5'd2;
        B = 5'd0;
        lat = 3;
        while (!ready && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if (lat !== 6 || {QUOTIENT, REMAINDER, div_by_zero} !== {5'd3, 5'd1, 1'b0}) begin
            bad++;
            $display("FAIL restart_ignored: got lat=%0d Q=%0d R=%0d dz=%b required lat=6 Q=3 R=1 dz=0",
                     lat, QUOTIENT, REMAINDER, div_by_zero);
        end
        A = 5'd9;
        B = 5'd3;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (ready !== 1'b1 || busy !== 1'b0 || QUOTIENT !== 5'd3 || REMAINDER !== 5'd1) begin
                bad++;
                $display("FAIL done_hold_%0d: got rdy=%b busy=%b Q=%0d R=%0d required rdy=1 busy=0 Q=3 R=1",
                         i, ready, busy, QUOTIENT, REMAINDER);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int bn;
        logic fr;
        @(posedge clk); #1;
        A = 5'd13;
        B = 5'd4;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_in_calc: got busy=%b required 1", busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if ({QUOTIENT, REMAINDER, q_neg, r_neg, div_by_zero, ready, busy} !== 15'd0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got Q=%0d R=%0d qn=%b rn=%b dz=%b rdy=%b busy=%b required all 0",
                     QUOTIENT, REMAINDER, q_neg, r_neg, div_by_zero, ready, busy);
        end
        run_op(9, 2, lat, bn, fr);
        total++;
        if (lat !== 6 || {QUOTIENT, REMAINDER, q_neg, r_neg} !== {5'd4, 5'd1, 2'b00}) begin
            bad++;
            $display("FAIL reset_mid_recovery: got lat=%0d Q=%0d R=%0d qn=%b rn=%b required lat=6 Q=4 R=1 qn=0 rn=0",
                     lat, QUOTIENT, REMAINDER, q_neg, r_neg);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        test_reset();
        test_basic();
        test_signs();
        test_div_zero();
        test_back_to_back();
        test_restart_ignored();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
